// File: rtl/uart_tx_scheduler_if.sv
// Bundle between the requesters, the scheduler and the uart transmitter.
// The slave modport is the scheduler's view; master is the environment's view.
interface uart_tx_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   grant;
    logic                 uart_start;
    logic [7:0]           uart_data;
    logic                 uart_busy;
    logic [IdW-1:0]       active_id;
    logic                 idle;
    logic                 err;

    modport master (
        output req, req_data, uart_busy,
        input  grant, uart_start, uart_data, active_id, idle, err
    );

    modport slave (
        input  req, req_data, uart_busy,
        output grant, uart_start, uart_data, active_id, idle, err
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart transmitter between NUM_REQ requesters.
// Issues a held start strobe per byte, then tracks the uart busy window with a timeout.
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned START_HOLD   = 10,
    parameter int unsigned BUSY_TIMEOUT = 64
) (
    input logic                clock,
    input logic                reset,
    uart_tx_scheduler_if.slave bus
);
    localparam int unsigned IdW    = $clog2(NUM_REQ);
    localparam int unsigned CntMax = (START_HOLD > BUSY_TIMEOUT) ? START_HOLD : BUSY_TIMEOUT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StWaitBusy,
        StWaitDone
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               start_q, start_d;
    logic [7:0]         data_q, data_d;
    logic [IdW-1:0]     id_q, id_d;
    logic               err_q, err_d;
    logic               idle_q, idle_d;

    logic               found;
    logic [IdW-1:0]     winner;
    logic [IdW-1:0]     rr_idx;

    // Round-robin search beginning just after the last granted requester.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        rr_idx = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            rr_idx = IdW'((int'(id_q) + k) % int'(NUM_REQ));
            if (!found && bus.req[rr_idx]) begin
                found  = 1'b1;
                winner = rr_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = '0;
        start_d = start_q;
        data_d  = data_q;
        id_d    = id_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (found && !bus.uart_busy) begin
                    grant_d[winner] = 1'b1;
                    data_d          = bus.req_data[{winner, 3'b000} +: 8];
                    id_d            = winner;
                    start_d         = 1'b1;
                    cnt_d           = '0;
                    state_d         = StHold;
                end
            end
            StHold: begin
                if (cnt_q == CntW'(START_HOLD - 1)) begin
                    start_d = 1'b0;
                    cnt_d   = '0;
                    state_d = StWaitBusy;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitBusy: begin
                if (bus.uart_busy) begin
                    state_d = StWaitDone;
                end else if (cnt_q == CntW'(BUSY_TIMEOUT - 1)) begin
                    // A uart that never answers is flagged but must not stall the others.
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitDone: begin
                if (!bus.uart_busy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        idle_d = (state_d == StIdle);
    end

    // Reset leaves the pointer on the last requester so requester 0 wins first.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            grant_q <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            id_q    <= IdW'(NUM_REQ - 1);
            err_q   <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            start_q <= start_d;
            data_q  <= data_d;
            id_q    <= id_d;
            err_q   <= err_d;
            idle_q  <= idle_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.uart_start = start_q;
    assign bus.uart_data  = data_q;
    assign bus.active_id  = id_q;
    assign bus.err        = err_q;
    assign bus.idle       = idle_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: vector table plus hand sequences, with a scoreboard of
// expected grants and a simple uart model that raises busy after the start strobe ends.
module tb_uart_tx_scheduler;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    uart_tx_scheduler_if bus ();

    logic        model_busy;
    logic        ext_busy;
    logic        model_en;
    int unsigned busy_len;
    assign bus.uart_busy = model_busy | ext_busy;

    uart_tx_scheduler dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int unsigned n;
        logic [7:0]  order;   // grant order, first id in [1:0]
        int unsigned busy_len;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[6];
    int         n_checks = 0;
    int         n_pass = 0;
    int         grants_seen = 0;
    int         start_len = 0;
    int         overlap_cnt = 0;
    logic [3:0] keep_mask = 4'b0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string need);
        n_checks++;
        $display("FAIL %s: got bound expiry, required %s", name, need);
    endtask

    // One cycle: sample at the falling edge, score any grant, drop granted requests.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        if (bus.grant != '0) begin
            grants_seen++;
            check("grant onehot", $countones(bus.grant), 1);
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected grant: got %b, expected none", bus.grant);
            end else begin
                e = sb.pop_front();
                check("grant vector", bus.grant, 32'd1 << e.id);
                check("uart_data at grant", bus.uart_data, e.data);
                check("active_id at grant", bus.active_id, e.id);
            end
            bus.req = bus.req & ~(bus.grant & ~keep_mask);
        end
        if (bus.uart_start && bus.uart_busy) overlap_cnt++;
        if (bus.uart_start) begin
            start_len++;
        end else if (start_len != 0) begin
            if (reset) check("uart_start length", start_len, 10);
            start_len = 0;
        end
    endtask

    task automatic run_until_done(input int max, input string name);
        int  k;
        logic done;
        k = 0;
        done = 1'b0;
        while (!done && k < max) begin
            tick();
            k++;
            done = (sb.size() == 0) && bus.idle && (bus.req == '0);
        end
        if (!done) fail_now(name, "scoreboard drained and idle");
    endtask

    task automatic wait_grant(input int max, input string name);
        int g0;
        int k;
        g0 = grants_seen;
        k = 0;
        while (grants_seen == g0 && k < max) begin
            tick();
            k++;
        end
        if (grants_seen == g0) fail_now(name, "a grant");
    endtask

    // Uart model: busy rises two cycles after uart_start falls, for busy_len cycles.
    initial begin : uart_model
        logic start_prev;
        model_busy = 1'b0;
        start_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (model_en && start_prev && !bus.uart_start) begin
                repeat (2) @(negedge clock);
                model_busy = 1'b1;
                repeat (busy_len) @(negedge clock);
                model_busy = 1'b0;
            end
            start_prev = bus.uart_start;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got time limit, required end of test");
        $fatal(1);
    end

    initial begin : main
        logic [1:0] id;
        int         g0;
        vecs[0] = '{4'b1111, 32'h4433_2211, 4, 8'b11_10_01_00, 20};
        vecs[1] = '{4'b0001, 32'h0000_00BA, 1, 8'b00_00_00_00, 100};
        vecs[2] = '{4'b1010, 32'h5500_AA00, 2, 8'b00_00_11_01, 20};
        vecs[3] = '{4'b0110, 32'h00C3_3C00, 2, 8'b00_00_10_01, 20};
        vecs[4] = '{4'b1001, 32'h7E00_00E7, 2, 8'b00_00_00_11, 20};
        vecs[5] = '{4'b0100, 32'h00FF_0000, 1, 8'b00_00_00_10, 20};

        ext_busy     = 1'b0;
        model_en     = 1'b1;
        busy_len     = 20;
        bus.req      = '0;
        bus.req_data = '0;
        reset        = 1'b1;
        #2 reset     = 1'b0;
        tick();
        tick();
        check("reset grant", bus.grant, 0);
        check("reset uart_start", bus.uart_start, 0);
        check("reset uart_data", bus.uart_data, 0);
        check("reset err", bus.err, 0);
        check("reset idle", bus.idle, 1);
        check("reset active_id", bus.active_id, 3);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            busy_len     = vecs[i].busy_len;
            bus.req_data = vecs[i].data;
            for (int k = 0; k < int'(vecs[i].n); k++) begin
                id = vecs[i].order[2*k +: 2];
                sb.push_back('{id, vecs[i].data[int'(id)*8 +: 8]});
            end
            bus.req = vecs[i].req;
            run_until_done(3000, "vector completion");
            check("vector final active_id", bus.active_id,
                  vecs[i].order[2*(int'(vecs[i].n)-1) +: 2]);
            check("vector err", bus.err, 0);
        end
        check("start/busy overlap", overlap_cnt, 0);

        // Fairness: requester 0 keeps asking, requester 2 asks once.
        busy_len     = 20;
        keep_mask    = 4'b0001;
        bus.req_data = 32'h0002_0001;
        sb.push_back('{2'd0, 8'h01});
        sb.push_back('{2'd2, 8'h02});
        sb.push_back('{2'd0, 8'h01});
        bus.req = 4'b0101;
        begin
            int k;
            k = 0;
            while (sb.size() != 0 && k < 2000) begin
                tick();
                k++;
            end
            if (sb.size() != 0) fail_now("fairness grants", "three grants 0,2,0");
        end
        bus.req[0] = 1'b0;
        keep_mask  = 4'b0000;
        run_until_done(2000, "fairness completion");

        // Timeout: uart never answers; err after 10 + 64 cycles; data stays captured.
        model_en     = 1'b0;
        bus.req_data = 32'h009C_0000;
        sb.push_back('{2'd2, 8'h9C});
        bus.req = 4'b0100;
        wait_grant(50, "timeout grant");
        bus.req_data = 32'hFFFF_FFFF;
        repeat (73) tick();
        check("err before timeout", bus.err, 0);
        check("uart_data held", bus.uart_data, 8'h9C);
        tick();
        check("err at timeout", bus.err, 1);
        check("idle after timeout", bus.idle, 1);
        model_en     = 1'b1;
        bus.req_data = 32'h0000_0077;
        sb.push_back('{2'd0, 8'h77});
        bus.req = 4'b0001;
        run_until_done(2000, "grant after timeout");
        check("err sticky", bus.err, 1);

        // External busy blocks grants; grant lands one cycle after busy falls.
        ext_busy     = 1'b1;
        bus.req_data = 32'h0000_3A00;
        bus.req      = 4'b0010;
        g0 = grants_seen;
        repeat (8) tick();
        check("no grant while busy", grants_seen, g0);
        ext_busy = 1'b0;
        sb.push_back('{2'd1, 8'h3A});
        tick();
        check("grant right after busy falls", grants_seen, g0 + 1);
        run_until_done(2000, "busy-at-request completion");

        // Request rises in the same cycle busy falls in WAIT_DONE.
        model_en     = 1'b0;
        bus.req_data = 32'h8100_0000;
        sb.push_back('{2'd3, 8'h81});
        bus.req = 4'b1000;
        wait_grant(50, "wait_done grant");
        begin
            int k;
            k = 0;
            while (bus.uart_start && k < 20) begin
                tick();
                k++;
            end
            if (bus.uart_start) fail_now("start release", "uart_start low");
        end
        ext_busy = 1'b1;
        repeat (3) tick();
        ext_busy     = 1'b0;
        model_en     = 1'b1;
        bus.req_data = 32'h0042_0000;
        bus.req      = 4'b0100;
        sb.push_back('{2'd2, 8'h42});
        g0 = grants_seen;
        tick();
        check("no grant on busy-fall cycle", grants_seen, g0);
        check("idle on busy-fall cycle", bus.idle, 1);
        tick();
        check("grant on following idle cycle", grants_seen, g0 + 1);
        run_until_done(2000, "wait_done completion");

        // Withdrawn request is never granted.
        ext_busy = 1'b1;
        bus.req  = 4'b0001;
        repeat (3) tick();
        bus.req  = 4'b0000;
        ext_busy = 1'b0;
        g0 = grants_seen;
        repeat (6) tick();
        check("withdrawn not granted", grants_seen, g0);
        check("idle after withdraw", bus.idle, 1);

        // Reset in the fifth HOLD cycle.
        model_en     = 1'b0;
        bus.req_data = 32'h0000_00D5;
        sb.push_back('{2'd0, 8'hD5});
        bus.req = 4'b0001;
        wait_grant(50, "pre-reset grant");
        repeat (4) tick();
        check("err before reset", bus.err, 1);
        check("start in HOLD", bus.uart_start, 1);
        #2 reset = 1'b0;
        #1;
        check("reset uart_start", bus.uart_start, 0);
        check("reset uart_data", bus.uart_data, 0);
        check("reset err clears", bus.err, 0);
        check("reset idle", bus.idle, 1);
        check("reset active_id", bus.active_id, 3);
        check("reset grant", bus.grant, 0);
        tick();
        reset = 1'b1;
        repeat (2) tick();
        model_en     = 1'b1;
        bus.req_data = 32'h006B_00C1;
        sb.push_back('{2'd0, 8'hC1});
        sb.push_back('{2'd2, 8'h6B});
        bus.req = 4'b0101;
        run_until_done(2000, "post-reset grants");
        check("final overlap", overlap_cnt, 0);
        check("final err", bus.err, 0);
        check("scoreboard empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one uart transmitter (fixed at 4 in this revision).
REQ-002 The block SHALL have parameter START_HOLD, default 10, giving the number of clock cycles uart_start is held high per byte.
REQ-003 The block SHALL have parameter BUSY_TIMEOUT, default 64, giving the maximum cycles to wait for uart_busy to rise after start.
REQ-004 The block SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port req  input  4  per-requester transmit request, level, held until granted.
REQ-007 The block SHALL have port req_data  input  32  byte for requester i on bits [8i+7:8i].
REQ-008 The block SHALL have port grant  output  4  one-hot, single-cycle pulse: byte of that requester captured.
REQ-009 The block SHALL have port uart_start  output  1  start strobe to the uart transmitter.
REQ-010 The block SHALL have port uart_data  output  8  byte presented to the uart data_in.
REQ-011 The block SHALL have port uart_busy  input  1  high while the uart shifts a frame.
REQ-012 The block SHALL have port active_id  output  2  index of the last granted requester.
REQ-013 The block SHALL have port idle  output  1  high only in state IDLE.
REQ-014 The block SHALL have port err  output  1  sticky timeout flag.

Function
REQ-015 States SHALL be IDLE, HOLD, WAIT_BUSY and WAIT_DONE, one-hot or encoded.
REQ-016 In IDLE, with req!=0 and uart_busy=0, the block SHALL in one cycle choose a winner, pulse its grant bit, load uart_data from its byte, set active_id, assert uart_start and enter HOLD.
REQ-017 Arbitration SHALL be round-robin: search order starts at (active_id+1) mod 4 and wraps; the pointer updates only on a grant.
REQ-018 In IDLE with uart_busy=1, no grant SHALL be issued, whatever req is.
REQ-019 uart_start SHALL be high for exactly START_HOLD consecutive cycles, beginning the cycle after the grant decision, then low; state moves to WAIT_BUSY.
REQ-020 uart_data SHALL remain stable from capture until the next grant, independent of req_data changes.
REQ-021 In WAIT_BUSY, uart_busy=1 SHALL move to WAIT_DONE. If uart_busy is still low after BUSY_TIMEOUT cycles, the block SHALL set err and return to IDLE.
REQ-022 In WAIT_DONE, uart_busy=0 SHALL return to IDLE, so the next grant is no earlier than 2 cycles after uart_busy falls.
REQ-023 A requester dropping req before its grant SHALL be treated as withdrawn; no grant is issued to it.
REQ-024 Requests arriving while not in IDLE SHALL be held pending by the requester and served in round-robin order afterward; none are lost or granted twice.
REQ-025 At most one grant bit SHALL be high in any cycle, and only in the IDLE->HOLD transition cycle.
REQ-026 err SHALL clear only on reset; a timeout SHALL NOT block further grants.
REQ-027 Simultaneous req rise and uart_busy fall in WAIT_DONE SHALL produce the grant on the following IDLE cycle.

Reset
REQ-028 reset low SHALL immediately force IDLE, grant=0, uart_start=0, uart_data=0, err=0 and idle=1, with active_id=3 so that requester 0 wins first.
REQ-029 reset asserted mid-HOLD or mid-WAIT_DONE SHALL drop uart_start at once, and the pending byte SHALL be discarded.
REQ-030 After reset rises, the first grant SHALL occur no earlier than the next rising clock edge.

Verification
REQ-031 Single request: req=0001 and req_data[7:0]=8'hBA, with a uart model raising busy 2 cycles after start for 100 cycles. Expected: grant=0001 for 1 cycle, uart_start high 10 cycles, uart_data=8'hBA, idle returns after busy falls.
REQ-032 All requesters: req=1111 and held after each grant until dropped. Expected: grant order 0,1,2,3, with each byte on uart_data in turn and no overlap of uart_start with uart_busy.
REQ-033 Fairness: requester 0 requests continuously while requester 2 requests once. Expected: requester 2 is granted no later than the second grant.
REQ-034 Timeout: uart_busy tied low and req=0100. Expected: err=1 after 10+64 cycles, the block returns to IDLE, and the next grant proceeds.
REQ-035 Reset mid-HOLD: reset low at cycle 5 of HOLD. Expected: uart_start=0 and uart_data=0 immediately, err=0, idle=1, active_id=3.
REQ-036 Busy at request: uart_busy=1 externally while req=0010. Expected: no grant until 1 cycle after busy falls.
